// File: rtl/vga_pkg.sv
// vga_pkg: 640x480 timing constants and receiver FSM state.
// Shared by vga_sync_rx and its sync_edge stages.
package vga_pkg;
  localparam int H_TOTAL_DEF  = 800;
  localparam int V_TOTAL_DEF  = 525;
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  localparam logic [9:0] CNT_MAX = 10'h3ff;

  typedef enum logic [1:0] {
    SEARCH,
    MEASURE,
    LOCKED
  } rx_state_e;
endpackage

// File: rtl/vga_sync_rx_sync_edge.sv
// sync_edge: one input register stage plus falling-edge detect.
// lvl_o is the registered copy aligned with fall_o's history.
module sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic lvl_o,
  output logic fall_o
);
  logic q_q;
  logic dly_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q   <= 1'b0;
      dly_q <= 1'b0;
    end else begin
      q_q   <= d_i;
      dly_q <= q_q;
    end
  end

  assign lvl_o  = dly_q;
  assign fall_o = dly_q & ~q_q;
endmodule

// File: rtl/vga_sync_rx.sv
// vga_sync_rx: recovers pixel address and lock from HS/VS/BLANK.
// Define VGA_RX_STATS_EN to add frame and error counters.
module vga_sync_rx
  import vga_pkg::*;
#(
  parameter int H_TOTAL  = H_TOTAL_DEF,
  parameter int V_TOTAL  = V_TOTAL_DEF,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iHS,
  input  logic        iVS,
  input  logic        iBLANK,
  output logic [9:0]  oPX,
  output logic [9:0]  oPY,
  output logic        oVALID,
  output logic        oFRAME,
  output logic        oLOCK,
  output logic        oERR,
  output logic [9:0]  oLINE_LEN
`ifdef VGA_RX_STATS_EN
  ,
  output logic [15:0] oFRAME_CNT,
  output logic [7:0]  oERR_CNT
`endif
);
  localparam logic [9:0] HT = 10'(H_TOTAL);
  localparam logic [9:0] VT = 10'(V_TOTAL);
  localparam logic [9:0] HA = 10'(H_ACTIVE);
  localparam logic [9:0] VA = 10'(V_ACTIVE);

  logic hs_lvl, hs_fall;
  logic vs_lvl, vs_fall;
  logic bl_lvl, bl_fall;
  logic unused_lvl;

  sync_edge u_hs (
    .clk_i (iCLK), .rst_i (iRST), .d_i (iHS),
    .lvl_o (hs_lvl), .fall_o (hs_fall)
  );
  sync_edge u_vs (
    .clk_i (iCLK), .rst_i (iRST), .d_i (iVS),
    .lvl_o (vs_lvl), .fall_o (vs_fall)
  );
  sync_edge u_bl (
    .clk_i (iCLK), .rst_i (iRST), .d_i (iBLANK),
    .lvl_o (bl_lvl), .fall_o (bl_fall)
  );

  assign unused_lvl = hs_lvl ^ vs_lvl;

  rx_state_e  state_q;
  logic [9:0] hcnt_q, vcnt_q;
  logic [9:0] px_q, py_q, len_q;
  logic       line_bad_q, frame_q, err_q;

  logic       sat, line_mis, frame_ok, lock_mis, err_d;
  logic [9:0] len_d, vlines_d;

  // The line closed by a coincident HS fall still belongs to this frame.
  assign sat      = (hcnt_q == CNT_MAX);
  assign len_d    = sat ? CNT_MAX : hcnt_q + 10'd1;
  assign line_mis = (hs_fall && len_d != HT) || sat;
  assign vlines_d = (hs_fall && vcnt_q != CNT_MAX)
                  ? vcnt_q + 10'd1 : vcnt_q;
  assign frame_ok = !line_bad_q && !line_mis
                 && (vlines_d == VT);
  assign lock_mis = line_mis || (vs_fall && vlines_d != VT);
  assign err_d    = (state_q == LOCKED) && lock_mis;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q    <= SEARCH;
      hcnt_q     <= '0;
      vcnt_q     <= '0;
      px_q       <= '0;
      py_q       <= '0;
      len_q      <= '0;
      line_bad_q <= 1'b0;
      frame_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      hcnt_q  <= hs_fall ? '0 : (sat ? hcnt_q : hcnt_q + 10'd1);
      vcnt_q  <= vs_fall ? '0 : vlines_d;
      frame_q <= vs_fall;
      err_q   <= err_d;
      if (hs_fall)
        len_q <= len_d;
      if (hs_fall)
        px_q <= '0;
      else if (bl_lvl)
        px_q <= px_q + 10'd1;
      if (vs_fall)
        py_q <= '0;
      else if (bl_fall)
        py_q <= py_q + 10'd1;
      if (vs_fall)
        line_bad_q <= 1'b0;
      else if (line_mis)
        line_bad_q <= 1'b1;
      unique case (state_q)
        SEARCH:  if (vs_fall) state_q <= MEASURE;
        MEASURE: if (vs_fall && frame_ok) state_q <= LOCKED;
        LOCKED:  if (lock_mis) state_q <= SEARCH;
        default: state_q <= SEARCH;
      endcase
    end
  end

  assign oPX       = px_q;
  assign oPY       = py_q;
  assign oLINE_LEN = len_q;
  assign oFRAME    = frame_q;
  assign oERR      = err_q;
  assign oLOCK     = (state_q == LOCKED);
  assign oVALID    = oLOCK && bl_lvl && (px_q < HA) && (py_q < VA);

`ifdef VGA_RX_STATS_EN
  logic [15:0] fcnt_q;
  logic [7:0]  ecnt_q;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      fcnt_q <= '0;
      ecnt_q <= '0;
    end else begin
      if (vs_fall)
        fcnt_q <= fcnt_q + 16'd1;
      if (err_d && ecnt_q != 8'hff)
        ecnt_q <= ecnt_q + 8'd1;
    end
  end

  assign oFRAME_CNT = fcnt_q;
  assign oERR_CNT   = ecnt_q;
`endif
endmodule
